// File: rtl/alink_tx_ctrl_pkg.sv
// alink_tx_ctrl_pkg: shared widths and state encoding for the alink TX
// controller. Holds no ports; imported by alink_tx_ctrl.
package alink_tx_ctrl_pkg;

  localparam int WORD_W      = 32;
  localparam int FRAME_CNT_W = 32;
  localparam int WORD_CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_SEND   = 3'd3,
    S_TSTART = 3'd4,
    S_WAIT   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/alink_tx_ctrl.sv
// alink_tx_ctrl: moves fixed-length frames of 32-bit words from the TX FIFO
// to the TX PHY, one word at a time, then kicks tx_timer and holds off the
// next frame until the response window has closed.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reg_enable          allow new frames to start (sampled in IDLE only)
//   reg_flush           abort current activity, return to IDLE
//   reg_word_cnt        words per frame, 0 = send nothing (sampled in IDLE)
//   fifo_count          TX FIFO occupancy (sampled in IDLE)
//   fifo_rd_en          FIFO read strobe, data valid the following cycle
//   fifo_dout           FIFO read data
//   phy_valid/phy_data  word offered to the PHY
//   phy_ready           PHY accepts the word
//   timer_start         one-cycle pulse to tx_timer after each frame
//   timer_busy          tx_timer response window open
//   tx_busy             state is not IDLE
//   frame_cnt           completed frames, wraps at 2^32
//
// state  | meaning
// IDLE   | waiting for enable, nonzero length, enough FIFO data, timer idle
// FETCH  | FIFO read strobe high for this cycle
// LATCH  | FIFO data arrives, captured into phy_data
// SEND   | phy_valid held until phy_ready
// TSTART | timer_start high for this cycle
// WAIT   | waiting for timer_busy to drop
module alink_tx_ctrl
  import alink_tx_ctrl_pkg::*;
#(
  parameter int FIFO_AW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reg_enable,
  input  logic                   reg_flush,
  input  logic [WORD_CNT_W-1:0]  reg_word_cnt,
  input  logic [FIFO_AW-1:0]     fifo_count,
  output logic                   fifo_rd_en,
  input  logic [WORD_W-1:0]      fifo_dout,
  output logic                   phy_valid,
  output logic [WORD_W-1:0]      phy_data,
  input  logic                   phy_ready,
  output logic                   timer_start,
  input  logic                   timer_busy,
  output logic                   tx_busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  tx_state_e              state_q, state_d;
  logic [WORD_CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic                   fifo_rd_en_q, fifo_rd_en_d;
  logic                   phy_valid_q, phy_valid_d;
  logic [WORD_W-1:0]      phy_data_q, phy_data_d;
  logic                   timer_start_q, timer_start_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic start_ok;
  logic last_word;

  // Occupancy is checked against the whole frame up front so the FIFO can
  // never run dry in the middle of a frame.
  assign start_ok = reg_enable && (reg_word_cnt != '0) &&
                    (32'(fifo_count) >= 32'(reg_word_cnt)) && !timer_busy;

  // Frame length is captured at frame start so mid-frame register writes
  // cannot shorten or stretch the frame in flight.
  assign last_word = (word_idx_q == word_cnt_q - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_idx_q    <= '0;
      word_cnt_q    <= '0;
      fifo_rd_en_q  <= 1'b0;
      phy_valid_q   <= 1'b0;
      phy_data_q    <= '0;
      timer_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      word_cnt_q    <= word_cnt_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      phy_valid_q   <= phy_valid_d;
      phy_data_q    <= phy_data_d;
      timer_start_q <= timer_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Registered strobes are set on the transition into the state that owns
  // them, so fifo_rd_en is high exactly while in FETCH and timer_start
  // exactly while in TSTART.
  always_comb begin
    state_d       = state_q;
    word_idx_d    = word_idx_q;
    word_cnt_d    = word_cnt_q;
    fifo_rd_en_d  = 1'b0;
    phy_valid_d   = phy_valid_q;
    phy_data_d    = phy_data_q;
    timer_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (reg_flush) begin
      state_d     = S_IDLE;
      word_idx_d  = '0;
      phy_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_d      = S_FETCH;
            word_idx_d   = '0;
            word_cnt_d   = reg_word_cnt;
            fifo_rd_en_d = 1'b1;
          end
        end
        S_FETCH: begin
          state_d = S_LATCH;
        end
        S_LATCH: begin
          phy_data_d  = fifo_dout;
          phy_valid_d = 1'b1;
          state_d     = S_SEND;
        end
        S_SEND: begin
          if (phy_ready) begin
            phy_valid_d = 1'b0;
            if (last_word) begin
              state_d       = S_TSTART;
              timer_start_d = 1'b1;
              frame_cnt_d   = frame_cnt_q + 32'd1;
            end else begin
              state_d      = S_FETCH;
              word_idx_d   = word_idx_q + 8'd1;
              fifo_rd_en_d = 1'b1;
            end
          end
        end
        S_TSTART: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (!timer_busy) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en  = fifo_rd_en_q;
  assign phy_valid   = phy_valid_q;
  assign phy_data    = phy_data_q;
  assign timer_start = timer_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign tx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alink_tx_ctrl.sv
// tb_alink_tx_ctrl: directed bench for alink_tx_ctrl with a FIFO model, a
// tx_timer model and a frame-timeline reference model checked every cycle.
module tb_alink_tx_ctrl;

  localparam int FIFO_AW = 10;
  localparam int TOUT    = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               reg_enable;
  logic               reg_flush;
  logic [7:0]         reg_word_cnt;
  logic [FIFO_AW-1:0] fifo_count;
  logic               fifo_rd_en;
  logic [31:0]        fifo_dout = '0;
  logic               phy_valid;
  logic [31:0]        phy_data;
  logic               phy_ready;
  logic               timer_start;
  logic               timer_busy;
  logic               tx_busy;
  logic [31:0]        frame_cnt;

  alink_tx_ctrl #(.FIFO_AW(FIFO_AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_enable   (reg_enable),
    .reg_flush    (reg_flush),
    .reg_word_cnt (reg_word_cnt),
    .fifo_count   (fifo_count),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_dout    (fifo_dout),
    .phy_valid    (phy_valid),
    .phy_data     (phy_data),
    .phy_ready    (phy_ready),
    .timer_start  (timer_start),
    .timer_busy   (timer_busy),
    .tx_busy      (tx_busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // FIFO: writes by the stimulus, reads by the strobe, data one cycle later.
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_count = FIFO_AW'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // tx_timer: window opens the cycle after timer_start, lasts TOUT cycles.
  int tcnt = 0;
  always @(posedge clk) begin
    if (rst)              tcnt <= 0;
    else if (timer_start) tcnt <= TOUT;
    else if (tcnt != 0)   tcnt <= tcnt - 1;
  end
  assign timer_busy = (tcnt != 0);

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a timeline of absolute cycle numbers for the next
  // fetch, the next timer kick and the word currently on offer.
  int          m_cyc = 0;
  int          m_left = 0;
  int          m_fetch_at = -10;
  int          m_tstart_at = -10;
  bit          m_waiting = 0;
  bit          m_presenting = 0;
  bit          m_idle;
  int          m_rptr = 0;
  logic [31:0] m_word = '0;
  bit          started = 0;
  logic        exp_rd_en, exp_valid, exp_tstart, exp_busy;
  logic [31:0] exp_data, exp_fcnt;
  logic [31:0] hs_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (m_fetch_at == m_cyc) begin
      m_word = mem[m_rptr % 256];
      m_rptr++;
    end
    if (rst) begin
      m_left = 0; m_fetch_at = -10; m_tstart_at = -10;
      m_waiting = 0; m_presenting = 0;
      exp_data = '0; exp_fcnt = '0;
    end else if (reg_flush) begin
      m_left = 0; m_fetch_at = -10; m_tstart_at = -10;
      m_waiting = 0; m_presenting = 0;
    end else begin
      m_idle = (m_left == 0) && (m_tstart_at != m_cyc) && !m_waiting;
      if (m_waiting) begin
        if (!timer_busy) m_waiting = 0;
      end else if (m_tstart_at == m_cyc) begin
        m_waiting = 1;
      end
      if (m_presenting) begin
        if (phy_ready) begin
          m_presenting = 0;
          m_left--;
          if (m_left == 0) begin
            m_tstart_at = m_cyc + 1;
            exp_fcnt++;
          end else begin
            m_fetch_at = m_cyc + 1;
          end
        end
      end else if (m_left != 0 && m_fetch_at == m_cyc - 1) begin
        m_presenting = 1;
        exp_data = m_word;
      end
      if (m_idle && reg_enable && reg_word_cnt != 0 &&
          int'(fifo_count) >= int'(reg_word_cnt) && !timer_busy) begin
        m_left = int'(reg_word_cnt);
        m_fetch_at = m_cyc + 1;
      end
    end
    exp_rd_en  = (m_fetch_at == m_cyc + 1);
    exp_tstart = (m_tstart_at == m_cyc + 1);
    exp_valid  = m_presenting;
    exp_busy   = (m_left != 0) || (m_tstart_at == m_cyc + 1) || m_waiting;
    m_cyc++;
    started = 1;
  endtask

  task automatic compare_cycle();
    if (started) begin
      chk("fifo_rd_en",  fifo_rd_en,  exp_rd_en);
      chk("phy_valid",   phy_valid,   exp_valid);
      chk("phy_data",    phy_data,    exp_data);
      chk("timer_start", timer_start, exp_tstart);
      chk("tx_busy",     tx_busy,     exp_busy);
      chk("frame_cnt",   frame_cnt,   exp_fcnt);
      if (phy_valid && phy_ready) hs_log.push_back(phy_data);
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, then leave the caller 1 time unit after the edge to drive inputs.
  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (tx_busy && n < max) begin
      step();
      n++;
    end
    chk(name, tx_busy, 1'b0);
  endtask

  initial begin
    int cnt;
    int busy_cnt;
    rst = 1'b1; reg_enable = 1'b0; reg_flush = 1'b0;
    reg_word_cnt = 8'd0; phy_ready = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    chk("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    chk("rst_phy_valid", phy_valid, 1'b0);
    chk("rst_phy_data", phy_data, 32'h0);
    chk("rst_timer_start", timer_start, 1'b0);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 32'h0);
    step(); step();
    rst = 1'b0;
    step(); step();

    // Two-word frame with PHY always ready; cycle 0 is this cycle.
    push(32'hA5A5_0001); push(32'hA5A5_0002);
    push(32'hA5A5_0003); push(32'hA5A5_0004);
    reg_word_cnt = 8'd2; reg_enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) chk("f1_rd_en_c1", fifo_rd_en, 1'b1);
      if (k == 2) chk("f1_rd_en_c2", fifo_rd_en, 1'b0);
      if (k == 3) begin
        chk("f1_valid_c3", phy_valid, 1'b1);
        chk("f1_data_c3", phy_data, 32'hA5A5_0001);
      end
      if (k == 4) chk("f1_rd_en_c4", fifo_rd_en, 1'b1);
      if (k == 6) chk("f1_data_c6", phy_data, 32'hA5A5_0002);
      if (k == 7) begin
        chk("f1_tstart_c7", timer_start, 1'b1);
        chk("f1_frame_cnt_c7", frame_cnt, 32'd1);
      end
    end
    step();
    chk("f1_busy_first_wait", timer_busy, 1'b1);
    cnt = 0; busy_cnt = 0;
    while (timer_busy && busy_cnt < 100) begin
      if (fifo_rd_en) cnt++;
      step();
      busy_cnt++;
    end
    chk("rd_en_while_timer_busy", cnt, 0);
    chk("timer_busy_timeout", timer_busy, 1'b0);
    cnt = 0;
    while (!fifo_rd_en && cnt < 10) begin
      step();
      cnt++;
    end
    chk("gap_busy_fall_to_rd_en", cnt, 2);

    // Enable dropped mid-frame: this frame still completes, nothing follows.
    reg_enable = 1'b0;
    wait_idle("f2_idle_timeout", 200);
    chk("f2_frame_cnt", frame_cnt, 32'd2);
    chk("log_size_2frames", hs_log.size(), 4);
    if (hs_log.size() >= 4) begin
      chk("log_w0", hs_log[0], 32'hA5A5_0001);
      chk("log_w1", hs_log[1], 32'hA5A5_0002);
      chk("log_w2", hs_log[2], 32'hA5A5_0003);
      chk("log_w3", hs_log[3], 32'hA5A5_0004);
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_busy || fifo_rd_en) cnt++;
    end
    chk("idle_after_enable_low", cnt, 0);

    // PHY backpressure: ready low for 5 SEND cycles on the first word.
    phy_ready = 1'b0;
    push(32'hB000_0001); push(32'hB000_0002);
    reg_word_cnt = 8'd2; reg_enable = 1'b1;
    step(); step(); step();
    chk("bp_valid_c3", phy_valid, 1'b1);
    chk("bp_data_c3", phy_data, 32'hB000_0001);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", phy_valid, 1'b1);
      chk("bp_hold_data", phy_data, 32'hB000_0001);
      chk("bp_no_rd_en", fifo_rd_en, 1'b0);
      step();
    end
    phy_ready = 1'b1;
    chk("bp_valid_on_ready", phy_valid, 1'b1);
    step();
    chk("bp_valid_after_hs", phy_valid, 1'b0);
    chk("bp_rd_en_after_hs", fifo_rd_en, 1'b1);
    chk("bp_log_size", hs_log.size(), 5);
    reg_enable = 1'b0;
    wait_idle("bp_idle_timeout", 200);
    chk("bp_frame_cnt", frame_cnt, 32'd3);
    chk("bp_log_size_end", hs_log.size(), 6);
    if (hs_log.size() >= 6) begin
      chk("bp_log_w0", hs_log[4], 32'hB000_0001);
      chk("bp_log_w1", hs_log[5], 32'hB000_0002);
    end

    // Insufficient data, then start, then flush on word 2 of 4.
    reg_word_cnt = 8'd4; reg_enable = 1'b1;
    push(32'hC000_0001); push(32'hC000_0002); push(32'hC000_0003);
    cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fifo_rd_en) cnt++;
      if (tx_busy) busy_cnt++;
    end
    chk("short_no_rd_en", cnt, 0);
    chk("short_no_busy", busy_cnt, 0);
    push(32'hC000_0004);
    step();
    chk("short_start_next", fifo_rd_en, 1'b1);
    step(); step(); step();
    phy_ready = 1'b0;
    step(); step();
    chk("fl_valid_w2", phy_valid, 1'b1);
    chk("fl_data_w2", phy_data, 32'hC000_0002);
    reg_flush = 1'b1;
    step();
    chk("fl_idle", tx_busy, 1'b0);
    chk("fl_valid", phy_valid, 1'b0);
    chk("fl_tstart", timer_start, 1'b0);
    chk("fl_frame_cnt", frame_cnt, 32'd3);
    reg_flush = 1'b0; reg_enable = 1'b0; phy_ready = 1'b1;
    wr_ptr = rd_ptr;
    step(); step();

    // Zero length, then disabled, with plenty of FIFO data.
    for (int i = 0; i < 8; i++) push(32'hD000_0000 + 32'(i));
    reg_word_cnt = 8'd0; reg_enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_busy || fifo_rd_en) cnt++;
    end
    chk("zero_len_no_activity", cnt, 0);
    reg_word_cnt = 8'd4; reg_enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_busy || fifo_rd_en) cnt++;
    end
    chk("disabled_no_activity", cnt, 0);
    chk("final_frame_cnt", frame_cnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
